// File: rtl/lcd_access_arbiter.sv
// lcd_access_arbiter: shares the LCD character-write port between full-screen
// refreshes (priority) and single keystrokes. It also owns the bottom-row cursor.
// Optional feature: define LCD_ACCESS_BACKSPACE_EN to make 8'h08 erase the
// character before the cursor.
module lcd_access_arbiter #(
  parameter int LINE_CHARS = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      refresh_req,
  input  logic [8*LINE_CHARS-1:0]   refresh_top,
  input  logic [8*LINE_CHARS-1:0]   refresh_bot,
  output logic                      refresh_ack,
  input  logic                      key_valid,
  input  logic [7:0]                key_ascii,
  output logic                      key_overflow,
  output logic                      lcd_valid,
  input  logic                      lcd_ready,
  output logic [$clog2(2*LINE_CHARS)-1:0] lcd_addr,
  output logic [7:0]                lcd_char,
  output logic [$clog2(2*LINE_CHARS)-1:0] cursor,
  output logic                      busy
);
  localparam int AW = $clog2(2*LINE_CHARS);
  localparam logic [AW-1:0] L_ZERO = '0;
  localparam logic [AW-1:0] L_ONE  = AW'(1);
  localparam logic [AW-1:0] L_BOT  = AW'(LINE_CHARS);
  localparam logic [AW-1:0] L_LAST = AW'(2*LINE_CHARS-1);

  typedef enum logic [1:0] {S_IDLE, S_REFRESH, S_KEY} state_t;

  state_t                  r_state, w_state_n;
  logic [16*LINE_CHARS-1:0] r_rows;          // {bot, top}: byte index == address
  logic [AW-1:0]           r_idx, w_idx_n, w_idx_inc;
  logic [AW-1:0]           r_cursor, w_cursor_n, w_cursor_adv;
  logic [AW-1:0]           r_addr, w_addr_n, w_key_addr;
  logic [7:0]              r_char, w_char_n, w_key_char;
  logic [7:0]              r_key_data;
  logic                    r_valid, w_valid_n, r_ack, w_ack_n;
  logic                    r_key_full, r_ovf, r_busy;
  logic                    w_drain, w_ovf_clr, w_load;
  logic                    w_print, w_bs, w_key_wr;

  // Classify the buffered key and precompute where/what it writes.
  always_comb begin
    w_print = (r_key_data >= 8'h20) && (r_key_data <= 8'h7E);
`ifdef LCD_ACCESS_BACKSPACE_EN
    w_bs = (r_key_data == 8'h08) && (r_cursor != L_BOT);
`else
    w_bs = 1'b0;
`endif
    w_key_wr     = w_print | w_bs;
    w_key_addr   = w_bs ? (r_cursor - L_ONE) : r_cursor;
    w_key_char   = w_bs ? 8'h20 : r_key_data;
    // Backspace leaves the cursor on the blanked cell; printables advance and wrap.
    w_cursor_adv = w_bs ? w_key_addr : ((r_cursor == L_LAST) ? L_BOT : (r_cursor + L_ONE));
    w_idx_inc    = r_idx + L_ONE;
  end

  // Next-state and next-output logic; outputs are loaded one cycle ahead so they register.
  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_cursor_n = r_cursor;
    w_addr_n   = r_addr;
    w_char_n   = r_char;
    w_valid_n  = r_valid;
    w_ack_n    = 1'b0;
    w_drain    = 1'b0;
    w_ovf_clr  = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (refresh_req) begin
          w_load    = 1'b1;
          w_ack_n   = 1'b1;
          w_idx_n   = L_ZERO;
          w_valid_n = 1'b1;
          w_addr_n  = L_ZERO;
          w_char_n  = refresh_top[7:0];
          w_state_n = S_REFRESH;
        end else if (r_key_full) begin
          w_state_n = S_KEY;
          if (w_key_wr) begin
            w_valid_n = 1'b1;
            w_addr_n  = w_key_addr;
            w_char_n  = w_key_char;
          end
        end
      end
      S_REFRESH: begin
        if (r_valid && lcd_ready) begin
          if (r_idx == L_LAST) begin
            w_valid_n  = 1'b0;
            w_cursor_n = L_BOT;
            w_ovf_clr  = 1'b1;
            w_state_n  = S_IDLE;
          end else begin
            w_idx_n  = w_idx_inc;
            w_addr_n = w_idx_inc;
            w_char_n = r_rows[{w_idx_inc, 3'b000} +: 8];
          end
        end
      end
      S_KEY: begin
        // Non-writing keys never raised lcd_valid: consume them immediately.
        if (!r_valid) begin
          w_drain   = 1'b1;
          w_state_n = S_IDLE;
        end else if (lcd_ready) begin
          w_drain    = 1'b1;
          w_valid_n  = 1'b0;
          w_cursor_n = w_cursor_adv;
          w_state_n  = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State, output and key-buffer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rows     <= '0;
      r_idx      <= L_ZERO;
      r_cursor   <= L_BOT;
      r_addr     <= L_ZERO;
      r_char     <= 8'h20;
      r_valid    <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_key_full <= 1'b0;
      r_key_data <= 8'h00;
      r_ovf      <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      r_cursor <= w_cursor_n;
      r_addr   <= w_addr_n;
      r_char   <= w_char_n;
      r_valid  <= w_valid_n;
      r_ack    <= w_ack_n;
      r_busy   <= (w_state_n != S_IDLE);
      if (w_load) r_rows <= {refresh_bot, refresh_top};
      if (w_ovf_clr) r_ovf <= 1'b0;
      // A key landing on the draining edge refills the buffer instead of overflowing.
      if (w_drain) begin
        r_key_full <= key_valid;
        if (key_valid) r_key_data <= key_ascii;
      end else if (key_valid) begin
        if (!r_key_full) begin
          r_key_full <= 1'b1;
          r_key_data <= key_ascii;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign refresh_ack  = r_ack;
  assign key_overflow = r_ovf;
  assign lcd_valid    = r_valid;
  assign lcd_addr     = r_addr;
  assign lcd_char     = r_char;
  assign cursor       = r_cursor;
  assign busy         = r_busy;
endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Directed bench for lcd_access_arbiter: refresh, keys, wrap, overflow,
// stall + async reset, and backspace handling (both builds).
module tb_lcd_access_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         refresh_req = 1'b0;
  logic [127:0] refresh_top = '0;
  logic [127:0] refresh_bot = '0;
  logic         refresh_ack;
  logic         key_valid = 1'b0;
  logic [7:0]   key_ascii = 8'h00;
  logic         key_overflow;
  logic         lcd_valid;
  logic         lcd_ready = 1'b1;
  logic [4:0]   lcd_addr;
  logic [7:0]   lcd_char;
  logic [4:0]   cursor;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [127:0] top_a;
  logic [127:0] bot_sp;

  lcd_access_arbiter #(.LINE_CHARS(16)) dut (
    .clock(clock), .reset(reset),
    .refresh_req(refresh_req), .refresh_top(refresh_top), .refresh_bot(refresh_bot),
    .refresh_ack(refresh_ack),
    .key_valid(key_valid), .key_ascii(key_ascii), .key_overflow(key_overflow),
    .lcd_valid(lcd_valid), .lcd_ready(lcd_ready), .lcd_addr(lcd_addr), .lcd_char(lcd_char),
    .cursor(cursor), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send_key(input logic [7:0] k);
    key_ascii = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Watches n cycles starting now; returns the first accepted write.
  task automatic watch_write(input int n, output bit found, output logic [4:0] a,
                             output logic [7:0] c);
    found = 1'b0;
    a = '0;
    c = '0;
    for (int i = 0; i < n; i++) begin
      if (lcd_valid && lcd_ready && !found) begin
        found = 1'b1;
        a = lcd_addr;
        c = lcd_char;
      end
      tick();
    end
  endtask

  task automatic do_refresh(input logic [127:0] t, input logic [127:0] b);
    int n;
    refresh_top = t;
    refresh_bot = b;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL refresh_timeout busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b1;
    tick();
    tick();
    total++;
    if (lcd_valid !== 1'b0 || lcd_addr !== 5'd0 || lcd_char !== 8'h20) begin
      bad++;
      $display("FAIL reset_lcd valid=%b addr=%0d char=%h want 0/0/20", lcd_valid, lcd_addr, lcd_char);
    end
    total++;
    if (refresh_ack !== 1'b0 || key_overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags ack=%b ovf=%b busy=%b want 0/0/0", refresh_ack, key_overflow, busy);
    end
    total++;
    if (cursor !== 5'd16) begin
      bad++;
      $display("FAIL reset_cursor got=%0d want 16", cursor);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_refresh;
    logic [7:0] exp;
    refresh_top = top_a;
    refresh_bot = bot_sp;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp = (k < 16) ? 8'(8'h41 + k) : 8'h20;
      total++;
      if (lcd_valid !== 1'b1 || lcd_addr !== 5'(k) || lcd_char !== exp) begin
        bad++;
        $display("FAIL refresh_xfer[%0d] valid=%b addr=%0d char=%h want 1/%0d/%h",
                 k, lcd_valid, lcd_addr, lcd_char, k, exp);
      end
      total++;
      if (refresh_ack !== (k == 0)) begin
        bad++;
        $display("FAIL refresh_ack[%0d] got=%b want %b", k, refresh_ack, (k == 0));
      end
      tick();
    end
    total++;
    if (lcd_valid !== 1'b0 || busy !== 1'b0 || cursor !== 5'd16) begin
      bad++;
      $display("FAIL refresh_end valid=%b busy=%b cursor=%0d want 0/0/16", lcd_valid, busy, cursor);
    end
  endtask

  task automatic test_key;
    send_key(8'h61);
    total++;
    if (lcd_valid !== 1'b0) begin
      bad++;
      $display("FAIL key_early valid=%b want 0", lcd_valid);
    end
    tick();
    total++;
    if (lcd_valid !== 1'b1 || lcd_addr !== 5'd16 || lcd_char !== 8'h61 || busy !== 1'b1) begin
      bad++;
      $display("FAIL key_write valid=%b addr=%0d char=%h busy=%b want 1/16/61/1",
               lcd_valid, lcd_addr, lcd_char, busy);
    end
    tick();
    total++;
    if (lcd_valid !== 1'b0 || cursor !== 5'd17 || busy !== 1'b0) begin
      bad++;
      $display("FAIL key_after valid=%b cursor=%0d busy=%b want 0/17/0", lcd_valid, cursor, busy);
    end
  endtask

  task automatic test_wrap;
    bit f;
    logic [4:0] a;
    logic [7:0] c;
    logic [7:0] k;
    do_refresh(top_a, bot_sp);
    for (int i = 0; i < 17; i++) begin
      k = 8'(8'h30 + i);
      send_key(k);
      watch_write(4, f, a, c);
      total++;
      if (!f || a !== ((i < 16) ? 5'(16 + i) : 5'd16) || c !== k) begin
        bad++;
        $display("FAIL wrap[%0d] found=%b addr=%0d char=%h want addr %0d char %h",
                 i, f, a, c, (i < 16) ? 16 + i : 16, k);
      end
    end
    total++;
    if (cursor !== 5'd17) begin
      bad++;
      $display("FAIL wrap_cursor got=%0d want 17", cursor);
    end
  endtask

  task automatic test_overflow;
    int cnt;
    bit f;
    logic [4:0] a;
    logic [7:0] c;
    // Idle case: second key arrives while the first is still buffered.
    send_key(8'h6D);
    send_key(8'h6E);
    tick(); tick(); tick();
    total++;
    if (key_overflow !== 1'b1 || lcd_valid !== 1'b0 || cursor !== 5'd18) begin
      bad++;
      $display("FAIL ovf_idle ovf=%b valid=%b cursor=%0d want 1/0/18", key_overflow, lcd_valid, cursor);
    end
    do_refresh(top_a, bot_sp);
    total++;
    if (key_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b want 0", key_overflow);
    end
    // Keys during a refresh: first waits, second is dropped.
    refresh_top = top_a;
    refresh_bot = bot_sp;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 32; i++) begin
      if (lcd_valid && lcd_ready) cnt++;
      key_valid = (i < 2);
      key_ascii = (i == 0) ? 8'h6B : 8'h7A;
      if (i == 5) begin
        total++;
        if (key_overflow !== 1'b1) begin
          bad++;
          $display("FAIL ovf_refresh got=%b want 1", key_overflow);
        end
      end
      tick();
    end
    key_valid = 1'b0;
    total++;
    if (cnt != 32 || key_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_refresh_end xfers=%0d ovf=%b want 32/0", cnt, key_overflow);
    end
    watch_write(4, f, a, c);
    total++;
    if (!f || a !== 5'd16 || c !== 8'h6B) begin
      bad++;
      $display("FAIL ovf_first_key found=%b addr=%0d char=%h want 16/6b", f, a, c);
    end
    tick(); tick(); tick(); tick();
    total++;
    if (lcd_valid !== 1'b0 || cursor !== 5'd17) begin
      bad++;
      $display("FAIL ovf_dropped valid=%b cursor=%0d want 0/17", lcd_valid, cursor);
    end
  endtask

  task automatic test_stall;
    refresh_top = top_a;
    refresh_bot = bot_sp;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    lcd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (lcd_valid !== 1'b1 || lcd_addr !== 5'd5 || lcd_char !== 8'h46) begin
        bad++;
        $display("FAIL stall[%0d] valid=%b addr=%0d char=%h want 1/5/46", i, lcd_valid, lcd_addr, lcd_char);
      end
      tick();
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (lcd_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_async_reset valid=%b want 0", lcd_valid);
    end
    total++;
    if (lcd_addr !== 5'd0 || lcd_char !== 8'h20 || cursor !== 5'd16 || busy !== 1'b0 ||
        refresh_ack !== 1'b0 || key_overflow !== 1'b0) begin
      bad++;
      $display("FAIL stall_reset_vals addr=%0d char=%h cursor=%0d busy=%b ack=%b ovf=%b",
               lcd_addr, lcd_char, cursor, busy, refresh_ack, key_overflow);
    end
    tick();
    reset = 1'b0;
    lcd_ready = 1'b1;
    tick(); tick(); tick();
    total++;
    if (lcd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_not_resumed valid=%b busy=%b want 0/0", lcd_valid, busy);
    end
  endtask

  task automatic test_backspace;
    bit f;
    logic [4:0] a;
    logic [7:0] c;
    send_key(8'h78);
    watch_write(4, f, a, c);
    total++;
    if (!f || a !== 5'd16 || c !== 8'h78) begin
      bad++;
      $display("FAIL bs_x found=%b addr=%0d char=%h want 16/78", f, a, c);
    end
    send_key(8'h08);
    watch_write(4, f, a, c);
`ifdef LCD_ACCESS_BACKSPACE_EN
    total++;
    if (!f || a !== 5'd16 || c !== 8'h20 || cursor !== 5'd16) begin
      bad++;
      $display("FAIL bs_erase found=%b addr=%0d char=%h cursor=%0d want 1/16/20/16", f, a, c, cursor);
    end
`else
    total++;
    if (f || cursor !== 5'd17 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bs_ignored found=%b cursor=%0d busy=%b want 0/17/0", f, cursor, busy);
    end
`endif
    // Enter is consumed with no write and no cursor change.
    send_key(8'h0D);
    watch_write(4, f, a, c);
    total++;
    if (f || busy !== 1'b0) begin
      bad++;
      $display("FAIL enter_nowrite found=%b busy=%b want 0/0", f, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) top_a[8*i +: 8] = 8'(8'h41 + i);
    bot_sp = {16{8'h20}};
    test_reset();
    test_refresh();
    test_key();
    test_wrap();
    test_overflow();
    test_stall();
    test_backspace();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_access_arbiter.md
# lcd_access_arbiter

Shares the single character-write port of the LCD driver between two requesters: full-screen refreshes (prompt row plus main row, on state changes or received messages) and single keystrokes from the PS/2 path. It sits between the display-state logic / keyboard decoder and the LCD writer. Refreshes take priority over keystrokes. The block also owns the typing cursor on the bottom row.

## Interface
- LINE_CHARS, 16, characters per LCD row; the address space is 2*LINE_CHARS.
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- refresh_req  in  1  request for a full-screen rewrite; held by the requester until refresh_ack.
- refresh_top  in  128  top-row text; char i = bits [8i+7:8i], i=0 is leftmost.
- refresh_bot  in  128  bottom-row text, same byte order.
- refresh_ack  out  1  one-cycle pulse; refresh_top/bot are captured on this cycle.
- key_valid  in  1  one-cycle strobe carrying a keystroke.
- key_ascii  in  8  ASCII code of the keystroke.
- key_overflow  out  1  sticky; set when a keystroke arrives while the buffer is full.
- lcd_valid  out  1  character write pending.
- lcd_ready  in  1  LCD writer accepts the pending character on this edge.
- lcd_addr  out  5  0..15 top row, 16..31 bottom row.
- lcd_char  out  8  character to write.
- cursor  out  5  next bottom-row write address (16..31).
- busy  out  1  high in any state other than IDLE.

## Operation
- State machine has three states: IDLE, REFRESH, KEY.
- Key buffer:
  - One-deep buffer (key_full, key_data).
  - key_valid with the buffer empty stores key_ascii.
  - key_valid with the buffer full drops the key and sets key_overflow.
  - A key arriving on the same edge the buffer drains is stored.
- IDLE:
  - If refresh_req is high, capture both rows, pulse refresh_ack, set index=0, and go to REFRESH.
  - Otherwise, if key_full, go to KEY.
  - refresh_req always wins over a buffered key.
- REFRESH:
  - lcd_valid=1, lcd_addr=index, lcd_char=byte index of {bot,top}, where index<16 selects top and index≥16 selects bot.
  - On lcd_valid&lcd_ready, index increments.
  - The transfer at index 31 sets cursor=16, clears key_overflow, and returns to IDLE.
  - refresh_req seen while in REFRESH is not acked until IDLE.
- KEY:
  - Printable (8'h20..8'h7E): write key_data at cursor. On transfer, cursor+1; 31 wraps to 16.
  - 8'h0D (enter), other non-printables, and backspace at cursor=16: no LCD write; the buffer is consumed in one cycle and the state returns to IDLE.
  - The buffer clears on the transfer or on consumption; the state then returns to IDLE.
- Outputs are registered. lcd_addr and lcd_char stay stable while lcd_valid=1 and lcd_ready=0.

## Timing
- Reset values: lcd_valid=0, lcd_addr=0, lcd_char=8'h20, refresh_ack=0, key_overflow=0, cursor=16, busy=0, buffer empty, state IDLE.
- Reset asserted mid-transfer drops lcd_valid asynchronously. A refresh in progress is abandoned, not resumed.
- refresh_req sampled at edge N in IDLE: refresh_ack=1 and lcd_valid=1 with addr 0 during cycle N+1.
- With lcd_ready held high, a refresh's last transfer occurs at edge N+32, and state is IDLE during N+33.
- Key strobe at edge N with the block idle: key_full during N+1, KEY during N+2, lcd_valid during N+2. That is 2 cycles of latency to lcd_valid.
- lcd_ready low stalls the block indefinitely with no timeout.

## Configuration
- LCD_ACCESS_BACKSPACE_EN defined:
  - 8'h08 is a printable-class command.
  - If cursor>16, cursor decrements and 8'h20 is written at the new cursor; cursor does not advance after that write.
  - If cursor=16, the key is consumed with no write.
- Undefined: 8'h08 is treated as non-printable and consumed with no write.

## Test plan
- Refresh, lcd_ready tied 1, top=bytes 8'h41..8'h50, bot=all 8'h20 -> 32 transfers at addr 0..31 with chars 'A'..'P' then 16 spaces; refresh_ack for exactly 1 cycle; cursor=16 afterwards.
- Key 8'h61 while idle -> lcd_valid 2 cycles later, addr 16, char 'a'; cursor=17.
- 17 printable keys spaced 5 cycles apart -> the 16th write is at addr 31, the 17th at addr 16 (wrap); cursor=17.
- Key strobe during a refresh, then a second strobe -> the first key is written at addr 16 right after the refresh; the second key is dropped and key_overflow=1; the next refresh clears key_overflow.
- lcd_ready=0 for 10 cycles at index 5, then reset pulse -> addr/char stable while stalled; lcd_valid falls asynchronously with reset; all outputs at reset values.
- With LCD_ACCESS_BACKSPACE_EN defined, keys 'x', 8'h08 -> writes addr 16 'x', then addr 16 8'h20; cursor=16. Without the macro, 8'h08 produces no write and cursor=17.
